// File: rtl/edc_pkg.sv
// -----------------------------------------------------------------------------
// edc_pkg
// Shared definitions for the write-side EDC encoder: data/ECC widths, the
// 32-entry H-matrix column table, the encoder FSM state enum and the ECC
// helper functions (check-bit generation, syndrome-to-bit decode).
// Optional feature macro used by the consumers of this package:
//   EDC_RMW_CORRECT_EN - single-bit correction of RMW read data.
// -----------------------------------------------------------------------------
package edc_pkg;

    localparam int DATA_W = 32;
    localparam int ECC_W  = 8;
    localparam int CODE_W = DATA_W + ECC_W;

    // H-matrix column for each data bit; index = data bit number.
    // Every column has weight 3, so any double-bit error yields an even-weight
    // syndrome that can never alias onto a single data-bit column.
    localparam logic [ECC_W-1:0] H_COL [DATA_W] = '{
        8'hA8, 8'h68, 8'hA4, 8'h64, 8'hA2, 8'h62, 8'hA1, 8'h61,
        8'h98, 8'h58, 8'h94, 8'h54, 8'h92, 8'h52, 8'h91, 8'h51,
        8'h8A, 8'h89, 8'h4A, 8'h49, 8'h2A, 8'h29, 8'h1A, 8'h19,
        8'h86, 8'h85, 8'h46, 8'h45, 8'h26, 8'h25, 8'h16, 8'h15
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RD_REQ  = 2'd2,
        RD_WAIT = 2'd3
    } state_e;

    // Check bit k is the XOR of every data bit whose column has bit k set.
    function automatic logic [ECC_W-1:0] calc_ecc(input logic [DATA_W-1:0] data);
        logic [ECC_W-1:0] ecc;
        ecc = {ECC_W{1'b0}};
        for (int k = 0; k < ECC_W; k++) begin
            for (int c = 0; c < DATA_W; c++) begin
                ecc[k] = ecc[k] ^ (data[c] & H_COL[c][k]);
            end
        end
        return ecc;
    endfunction

    // One-hot mask of the data bit whose column equals the syndrome; all-zero
    // when the syndrome is zero or matches no data column.
    function automatic logic [DATA_W-1:0] syndrome_mask(input logic [ECC_W-1:0] syn);
        logic [DATA_W-1:0] mask;
        mask = {DATA_W{1'b0}};
        for (int c = 0; c < DATA_W; c++) begin
            mask[c] = (syn == H_COL[c]);
        end
        return mask;
    endfunction

endpackage

// File: rtl/edc_ecc_gen.sv
// -----------------------------------------------------------------------------
// edc_ecc_gen
// Purely combinational check-bit generator for one 32-bit data word.
// Ports:
//   data : input  [31:0] data word
//   ecc  : output [7:0]  check bits per the edc_pkg H-matrix
// -----------------------------------------------------------------------------
module edc_ecc_gen
    import edc_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [ECC_W-1:0]  ecc
);

    assign ecc = calc_ecc(data);

endmodule

// File: rtl/edc_encoder.sv
// -----------------------------------------------------------------------------
// edc_encoder
// Write-side EDC encoder. Full-word writes are encoded and issued directly;
// partial writes do a read-modify-write: read the stored codeword, merge the
// enabled byte lanes, re-encode and write back. Zero-enable requests are
// consumed without memory traffic.
// Ports:
//   i_clk, i_rst              : clock, asynchronous active-high reset
//   i_req_*, o_req_ready      : write request (valid/ready), addr, data, be
//   o_mem_wr_*, i_mem_wr_ready: codeword write {ecc[7:0], data[31:0]}
//   o_mem_rd_*, i_mem_rd_ready: RMW read request
//   i_mem_rd_data(_valid)     : returned stored codeword
//   o_busy                    : FSM not in IDLE
//   o_rmw_error               : one-cycle pulse on uncorrectable RMW read
// Configuration:
//   EDC_RMW_CORRECT_EN defined   : RMW read data syndrome-checked, single-bit
//                                  errors corrected, others dropped + flagged.
//   EDC_RMW_CORRECT_EN undefined : raw read data merged, stored ECC ignored.
// -----------------------------------------------------------------------------
module edc_encoder
    import edc_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_data,
    input  logic [3:0]        i_req_be,
    output logic              o_mem_wr_valid,
    input  logic              i_mem_wr_ready,
    output logic [ADDR_W-1:0] o_mem_wr_addr,
    output logic [39:0]       o_mem_wr_data,
    output logic              o_mem_rd_valid,
    input  logic              i_mem_rd_ready,
    output logic [ADDR_W-1:0] o_mem_rd_addr,
    input  logic              i_mem_rd_data_valid,
    input  logic [39:0]       i_mem_rd_data,
    output logic              o_busy,
    output logic              o_rmw_error
);

    state_e              state_r;
    state_e              state_nxt_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   data_r;
    logic [ECC_W-1:0]    ecc_r;
    logic [3:0]          be_r;

    logic [DATA_W-1:0]   rd_src_s;     // read word after optional correction
    logic                rd_uncorr_s;  // read word cannot be repaired
    logic [DATA_W-1:0]   merged_s;
    logic [DATA_W-1:0]   enc_in_s;
    logic [ECC_W-1:0]    enc_ecc_s;

`ifdef EDC_RMW_CORRECT_EN
    logic [ECC_W-1:0]    rd_ecc_s;
    logic [ECC_W-1:0]    syn_s;
    logic [DATA_W-1:0]   flip_s;
    logic                rmw_error_r;

    edc_ecc_gen u_ecc_rd (
        .data (i_mem_rd_data[DATA_W-1:0]),
        .ecc  (rd_ecc_s)
    );

    assign syn_s       = rd_ecc_s ^ i_mem_rd_data[CODE_W-1:DATA_W];
    assign flip_s      = syndrome_mask(syn_s);
    assign rd_src_s    = i_mem_rd_data[DATA_W-1:0] ^ flip_s;
    // Nonzero syndrome that is no data column: multi-bit or check-bit error.
    assign rd_uncorr_s = (syn_s != {ECC_W{1'b0}}) && (flip_s == {DATA_W{1'b0}});

    // Error pulse: registered one cycle after the bad read data arrives.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rmw_error_r <= 1'b0;
        end else begin
            rmw_error_r <= (state_r == RD_WAIT) && i_mem_rd_data_valid && rd_uncorr_s;
        end
    end

    assign o_rmw_error = rmw_error_r;
`else
    logic unused_rd_ecc;

    // Stored check bits are not consulted without correction.
    assign unused_rd_ecc = ^i_mem_rd_data[CODE_W-1:DATA_W];
    assign rd_src_s      = i_mem_rd_data[DATA_W-1:0];
    assign rd_uncorr_s   = 1'b0;
    assign o_rmw_error   = 1'b0;
`endif

    // Byte-lane merge: enabled lanes from the registered request, others from memory.
    always_comb begin
        merged_s = {DATA_W{1'b0}};
        for (int n = 0; n < 4; n++) begin
            merged_s[8*n +: 8] = be_r[n] ? data_r[8*n +: 8] : rd_src_s[8*n +: 8];
        end
    end

    // One encoder serves both the incoming request and the merged RMW word.
    assign enc_in_s = (state_r == RD_WAIT) ? merged_s : i_req_data;

    edc_ecc_gen u_ecc_req (
        .data (enc_in_s),
        .ecc  (enc_ecc_s)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!i_req_valid) begin
                    state_nxt_s = IDLE;
                end else if (i_req_be == 4'hF) begin
                    state_nxt_s = WRITE;
                end else if (i_req_be == 4'h0) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RD_REQ;
                end
            end
            RD_REQ: begin
                if (i_mem_rd_ready) begin
                    state_nxt_s = RD_WAIT;
                end else begin
                    state_nxt_s = RD_REQ;
                end
            end
            RD_WAIT: begin
                if (!i_mem_rd_data_valid) begin
                    state_nxt_s = RD_WAIT;
                end else if (rd_uncorr_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WRITE;
                end
            end
            WRITE: begin
                if (i_mem_wr_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WRITE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Request/codeword registers: captured on accept, rewritten after merge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_r <= {ADDR_W{1'b0}};
            data_r <= {DATA_W{1'b0}};
            ecc_r  <= {ECC_W{1'b0}};
            be_r   <= 4'h0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_req_valid && (i_req_be != 4'h0)) begin
                        addr_r <= i_req_addr;
                        data_r <= i_req_data;
                        ecc_r  <= enc_ecc_s;
                        be_r   <= i_req_be;
                    end
                end
                RD_WAIT: begin
                    if (i_mem_rd_data_valid && !rd_uncorr_s) begin
                        data_r <= merged_s;
                        ecc_r  <= enc_ecc_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode from the registered state; the two valids are exclusive by construction.
    always_comb begin
        o_req_ready    = 1'b0;
        o_busy         = 1'b1;
        o_mem_wr_valid = 1'b0;
        o_mem_rd_valid = 1'b0;
        case (state_r)
            IDLE: begin
                o_req_ready = 1'b1;
                o_busy      = 1'b0;
            end
            WRITE: begin
                o_mem_wr_valid = 1'b1;
            end
            RD_REQ: begin
                o_mem_rd_valid = 1'b1;
            end
            RD_WAIT: begin
                o_busy = 1'b1;
            end
            default: begin
                o_busy = 1'b1;
            end
        endcase
    end

    assign o_mem_wr_addr = addr_r;
    assign o_mem_rd_addr = addr_r;
    assign o_mem_wr_data = {ecc_r, data_r};

endmodule

// File: doc/edc_encoder.md
EDC_ENCODER -- requirements
Module: edc_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, request/memory address width.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_req_valid  input  1  write request valid.
REQ-005 SHALL have port o_req_ready  output  1  request accepted when valid&ready.
REQ-006 SHALL have port i_req_addr  input  ADDR_W  word address.
REQ-007 SHALL have port i_req_data  input  32  write data; byte lane n = bits [8n+7:8n].
REQ-008 SHALL have port i_req_be  input  4  byte enables, bit n = lane n.
REQ-009 SHALL have port o_mem_wr_valid  output  1  codeword write valid.
REQ-010 SHALL have port i_mem_wr_ready  input  1  memory accepts write.
REQ-011 SHALL have port o_mem_wr_addr  output  ADDR_W  write address.
REQ-012 SHALL have port o_mem_wr_data  output  40  codeword {ecc[7:0], data[31:0]}.
REQ-013 SHALL have port o_mem_rd_valid  output  1  RMW read request.
REQ-014 SHALL have port i_mem_rd_ready  input  1  memory accepts read request.
REQ-015 SHALL have port o_mem_rd_addr  output  ADDR_W  read address.
REQ-016 SHALL have port i_mem_rd_data_valid  input  1  read data returned.
REQ-017 SHALL have port i_mem_rd_data  input  40  stored codeword {ecc, data}.
REQ-018 SHALL have port o_busy  output  1  high whenever state != IDLE.
REQ-019 SHALL have port o_rmw_error  output  1  one-cycle pulse: uncorrectable RMW read.

Function
REQ-020 Check bit k SHALL be XOR of data bits c whose H-column has bit k set; columns for data bits 0..31 (hex): A8 68 A4 64 A2 62 A1 61 98 58 94 54 92 52 91 51 8A 89 4A 49 2A 29 1A 19 86 85 46 45 26 25 16 15.
REQ-021 Any emitted codeword SHALL yield syndrome 0 (recomputed ECC XOR stored ECC) at the read-side decoder.
REQ-022 FSM states SHALL be IDLE, WRITE, RD_REQ, RD_WAIT; o_req_ready = (state==IDLE).
REQ-023 IDLE, accept with be==4'hF: register addr, data, ECC; next state WRITE; o_mem_wr_valid high the cycle after acceptance.
REQ-024 IDLE, accept with be==4'h0: request consumed, no memory traffic, stay IDLE.
REQ-025 IDLE, accept with partial be: register request; next state RD_REQ with o_mem_rd_valid high, o_mem_rd_addr = request addr.
REQ-026 RD_REQ SHALL hold o_mem_rd_valid/addr stable until i_mem_rd_ready, then RD_WAIT.
REQ-027 RD_WAIT on i_mem_rd_data_valid: lanes with be=1 from request, others from read data; ECC recomputed over merged word; next state WRITE.
REQ-028 WRITE SHALL hold o_mem_wr_valid/addr/data stable until i_mem_wr_ready, then IDLE (max throughput one full write per 2 cycles).
REQ-029 i_mem_rd_data_valid outside RD_WAIT SHALL be ignored; i_req_* ignored while not ready.
REQ-030 o_mem_wr_valid and o_mem_rd_valid SHALL never be high together.

Reset
REQ-031 i_rst SHALL immediately force IDLE; o_req_ready=1, o_mem_wr_valid=0, o_mem_rd_valid=0, o_busy=0, o_rmw_error=0, data/addr/ECC registers=0.
REQ-032 Reset mid-operation SHALL abandon the transaction without any further memory request.

Configuration
REQ-033 Macro EDC_RMW_CORRECT_EN defined: RMW read data SHALL be syndrome-checked before merge; syndrome equal to one H-column flips that data bit; nonzero unmatched syndrome pulses o_rmw_error, write dropped, return IDLE.
REQ-034 Macro undefined: raw read data merged, stored ECC ignored, o_rmw_error tied 0.

Structure
REQ-035 Package edc_pkg SHALL hold the 32-entry H-column constant table, ECC/data widths (8, 32) and the FSM state enum.
REQ-036 Check-bit generation SHALL be one combinational sub-module edc_ecc_gen (32-bit in, 8-bit out), instantiated for request path and, with EDC_RMW_CORRECT_EN, read path.

Verification
REQ-037 Full write data 0x00000001, be=F -> wr_data 0xA8_00000001 one cycle after accept.
REQ-038 Full write 0x00000003 with i_mem_wr_ready low 3 cycles -> 0xC0_00000003 held stable 4 cycles, then IDLE.
REQ-039 be=0001, data 0xAB, memory returns valid codeword of 0x12345678 -> wr_data data 0x123456AB, ECC matches model.
REQ-040 (EN) stored 0x12345678 with bit 20 flipped, original ECC, be=0001 data 0xAB -> write 0x123456AB.
REQ-041 (EN) two data bits flipped -> o_rmw_error pulse 1 cycle, no write, o_req_ready returns high.
REQ-042 i_rst asserted in RD_WAIT -> valids drop same cycle, later read data ignored, no write issued.
